key_cmd_scheduler: RTL and testbench

Sits between the PS/2 keyboard controller and the game logic. Turns decoded scan-code events into a small command set (cursor moves, select, cancel, restart) and generates timed auto-repeat for held arrow keys. Suppresses the keyboard's own typematic repeats. Buffers commands in a FIFO delivered to the consumer over a valid/ready handshake.

---
 rtl/key_cmd_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_key_cmd_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler: maps PS/2 make/break events to game commands,
// generates timed auto-repeat for a held arrow key while swallowing the
// keyboard's own typematic repeats, and queues commands in a small FIFO
// presented to the consumer over a valid/ready handshake.
module key_cmd_scheduler #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int DEPTH         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] kb_key,
  input  logic       kb_extend,
  input  logic       kb_break,
  input  logic       kb_valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       held,
  output logic [1:0] held_dir,
  output logic       overflow
);

  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int PTR_W   = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(DEPTH);

  localparam logic [2:0] CMD_SELECT  = 3'd4;
  localparam logic [2:0] CMD_CANCEL  = 3'd5;
  localparam logic [2:0] CMD_RESTART = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       dir_nx;

  // decoded event
  logic       is_arrow, is_other;
  logic [1:0] arrow_dir;
  logic [2:0] other_cmd;
  logic       arrow_make, arrow_break, other_make;

  // FSM outputs toward the FIFO
  logic       tick;
  logic       kb_wr, tick_wr;
  logic [2:0] kb_cmd;

  // FIFO
  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             wr_req, wr_ok, pop, full;
  logic [2:0]       wr_data;

  // Classify the scan code: arrows need the E0 prefix, the rest match either way.
  always_comb begin
    is_arrow  = 1'b0;
    arrow_dir = 2'd0;
    is_other  = 1'b0;
    other_cmd = 3'd0;
    if (kb_extend) begin
      case (kb_key)
        8'h75:   begin is_arrow = 1'b1; arrow_dir = 2'd0; end
        8'h72:   begin is_arrow = 1'b1; arrow_dir = 2'd1; end
        8'h6B:   begin is_arrow = 1'b1; arrow_dir = 2'd2; end
        8'h74:   begin is_arrow = 1'b1; arrow_dir = 2'd3; end
        default: ;
      endcase
    end
    case (kb_key)
      8'h5A, 8'h29: begin is_other = 1'b1; other_cmd = CMD_SELECT;  end
      8'h76:        begin is_other = 1'b1; other_cmd = CMD_CANCEL;  end
      8'h2D:        begin is_other = 1'b1; other_cmd = CMD_RESTART; end
      default: ;
    endcase
    arrow_make  = en && kb_valid && !kb_break && is_arrow;
    arrow_break = en && kb_valid &&  kb_break && is_arrow;
    other_make  = en && kb_valid && !kb_break && is_other;
  end

  // Repeat FSM next state: new arrow restarts the delay, held-arrow break
  // stops, otherwise the shared counter runs and fires repeat ticks.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = held_dir;
    kb_wr    = 1'b0;
    kb_cmd   = other_cmd;
    tick_wr  = 1'b0;
    tick     = ((state == ST_DELAY)  && (cnt == DELAY_LAST)) ||
               ((state == ST_REPEAT) && (cnt == PERIOD_LAST));
    if (!en) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else if (arrow_make && ((state == ST_IDLE) || (arrow_dir != held_dir))) begin
      kb_wr    = 1'b1;
      kb_cmd   = {1'b0, arrow_dir};
      dir_nx   = arrow_dir;
      state_nx = ST_DELAY;
      cnt_nx   = '0;
    end else if (arrow_break && (state != ST_IDLE) && (arrow_dir == held_dir)) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else begin
      // A typematic repeat of the held arrow lands here and changes nothing.
      kb_wr = other_make;
      if (tick) begin
        // Keyboard command wins the single write port; the tick is lost
        // but the repeat cadence keeps running from this edge.
        tick_wr  = !other_make;
        state_nx = ST_REPEAT;
        cnt_nx   = '0;
      end else if (state != ST_IDLE) begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end
  end

  // Repeat FSM state, shared counter and held direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      held_dir <= 2'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      held_dir <= dir_nx;
    end
  end

  assign held = (state != ST_IDLE);

  // FIFO write arbitration and handshake.
  always_comb begin
    wr_req  = kb_wr || tick_wr;
    wr_data = kb_wr ? kb_cmd : {1'b0, held_dir};
    full    = (count == FULL_COUNT);
    pop     = cmd_valid && cmd_ready;
    wr_ok   = wr_req && (!full || pop);
  end

  // FIFO storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + {{PTR_W{1'b0}}, wr_ok} - {{PTR_W{1'b0}}, pop};
      if (wr_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign cmd_valid = (count != '0);
  assign cmd       = cmd_valid ? mem[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Testbench for key_cmd_scheduler: directed scenarios plus random events,
// checked against a cycle-indexed reference model and a pop scoreboard.
module tb_key_cmd_scheduler;

  localparam int RD = 8;
  localparam int RP = 4;
  localparam int DP = 4;

  logic       clk = 1'b0;
  logic       rst, en, kb_extend, kb_break, kb_valid, cmd_ready;
  logic [7:0] kb_key;
  logic [2:0] cmd;
  logic       cmd_valid, held, overflow;
  logic [1:0] held_dir;

  key_cmd_scheduler #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .DEPTH        (DP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .kb_key   (kb_key),
    .kb_extend(kb_extend),
    .kb_break (kb_break),
    .kb_valid (kb_valid),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .held     (held),
    .held_dir (held_dir),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard of commands the consumer should receive, in order
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  // reference model state
  bit         m_held;
  logic [1:0] m_dir;
  longint     m_next;
  longint     edge_no;
  int         m_cnt;
  bit         m_ovf;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // kind: 0 unmapped, 1 arrow, 2 other command
  function automatic void map_code(input logic [7:0] k, input logic x,
                                   output int kind, output logic [2:0] c);
    kind = 0;
    c    = 3'd0;
    if (x && k == 8'h75)      begin kind = 1; c = 3'd0; end
    else if (x && k == 8'h72) begin kind = 1; c = 3'd1; end
    else if (x && k == 8'h6B) begin kind = 1; c = 3'd2; end
    else if (x && k == 8'h74) begin kind = 1; c = 3'd3; end
    else if (k == 8'h5A || k == 8'h29) begin kind = 2; c = 3'd4; end
    else if (k == 8'h76)      begin kind = 2; c = 3'd5; end
    else if (k == 8'h2D)      begin kind = 2; c = 3'd6; end
  endfunction

  // Advance the model by the edge about to happen, using the driven inputs.
  task automatic model_step();
    int         kind;
    logic [2:0] c;
    bit         fire, has_w, pop;
    logic [2:0] w;
    edge_no++;
    if (rst) begin
      m_held = 0; m_dir = 2'd0; m_cnt = 0; m_ovf = 0; m_next = 0;
      exp_q.delete();
      return;
    end
    pop   = (m_cnt > 0) && cmd_ready;
    has_w = 0;
    w     = 3'd0;
    if (en) begin
      map_code(kb_key, kb_extend, kind, c);
      fire = m_held && (edge_no == m_next);
      if (kb_valid && !kb_break && kind == 1 && (!m_held || c[1:0] != m_dir)) begin
        has_w = 1; w = c; m_held = 1; m_dir = c[1:0]; m_next = edge_no + RD; fire = 0;
      end else if (kb_valid && kb_break && kind == 1 && m_held && c[1:0] == m_dir) begin
        m_held = 0; fire = 0;
      end else if (kb_valid && !kb_break && kind == 2) begin
        has_w = 1; w = c;
      end
      if (fire) begin
        m_next = edge_no + RP;
        if (!has_w) begin has_w = 1; w = {1'b0, m_dir}; end
      end
    end else begin
      m_held = 0;
    end
    if (pop) m_cnt--;
    if (has_w) begin
      if (m_cnt < DP) begin
        m_cnt++;
        exp_q.push_back(w);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("cmd_valid", int'(cmd_valid), int'(m_cnt > 0));
    check("held",      int'(held),      int'(m_held));
    check("held_dir",  int'(held_dir),  int'(m_dir));
    check("overflow",  int'(overflow),  int'(m_ovf));
  endtask

  // One clock: check settled outputs, drive inputs, step model, advance.
  task automatic cyc(input logic r, input logic e, input logic v, input logic x,
                     input logic b, input logic [7:0] k, input logic rdy);
    check_outputs();
    rst = r; en = e; kb_valid = v; kb_extend = x; kb_break = b; kb_key = k; cmd_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic mk(input logic [7:0] k, input logic x, input logic rdy);
    cyc(1'b0, 1'b1, 1'b1, x, 1'b0, k, rdy);
  endtask

  task automatic brk(input logic [7:0] k, input logic x, input logic rdy);
    cyc(1'b0, 1'b1, 1'b1, x, 1'b1, k, rdy);
  endtask

  // Monitor: every accepted pop must match the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got cmd %0d, expected no pop (t=%0t)", cmd, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_cmd", int'(cmd), int'(mon_exp));
      end
    end
  end

  logic [7:0] codes [10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h29, 8'h76, 8'h2D, 8'h1C, 8'h12};

  initial begin
    m_held = 0; m_dir = 2'd0; m_cnt = 0; m_ovf = 0; m_next = 0; edge_no = 0;
    rst = 1'b1; en = 1'b1; kb_valid = 1'b0; kb_extend = 1'b0; kb_break = 1'b0;
    kb_key = 8'h00; cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    edge_no = 1;
    check("reset_cmd", int'(cmd), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // single UP make with consumer ready
    mk(8'h75, 1'b1, 1'b1);
    idle(3, 1'b1);
    brk(8'h75, 1'b1, 1'b1);
    idle(2, 1'b1);

    // hold RIGHT with keyboard typematic every 3 cycles, then release
    mk(8'h74, 1'b1, 1'b1);
    for (int i = 1; i < 18; i++) begin
      if (i % 3 == 0) mk(8'h74, 1'b1, 1'b1);
      else            idle(1, 1'b1);
    end
    brk(8'h74, 1'b1, 1'b1);
    idle(10, 1'b1);

    // fill with consumer stalled, unmapped code, then overflow, then drain
    mk(8'h5A, 1'b0, 1'b0);
    mk(8'h76, 1'b0, 1'b0);
    mk(8'h2D, 1'b0, 1'b0);
    mk(8'h29, 1'b0, 1'b0);
    mk(8'h1C, 1'b0, 1'b0);
    idle(1, 1'b0);
    mk(8'h5A, 1'b0, 1'b0);
    idle(6, 1'b1);

    // full FIFO with a simultaneous pop and write
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    mk(8'h5A, 1'b0, 1'b0);
    mk(8'h76, 1'b1, 1'b0);
    mk(8'h2D, 1'b0, 1'b0);
    mk(8'h29, 1'b0, 1'b0);
    mk(8'h5A, 1'b0, 1'b1);
    idle(6, 1'b1);

    // repeat tick colliding with a CANCEL make, then direction change
    mk(8'h6B, 1'b1, 1'b1);
    idle(7, 1'b1);
    mk(8'h76, 1'b0, 1'b1);
    idle(5, 1'b1);
    mk(8'h6B, 1'b1, 1'b1);
    idle(2, 1'b1);
    mk(8'h72, 1'b1, 1'b1);
    idle(10, 1'b1);
    brk(8'h6B, 1'b1, 1'b1);
    idle(2, 1'b1);
    brk(8'h72, 1'b1, 1'b1);
    idle(2, 1'b1);

    // reset while in REPEAT with three entries queued
    mk(8'h74, 1'b1, 1'b0);
    idle(13, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_mid_cmd", int'(cmd), 0);

    // arrow make while disabled
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h75, 1'b1);
    idle(3, 1'b1);
    mk(8'h72, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, e, v, x, b, rdy;
      logic [7:0] k;
      r   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 59) != 0);
      v   = ($urandom_range(0, 99) < 25);
      x   = ($urandom_range(0, 99) < 70);
      b   = ($urandom_range(0, 99) < 30);
      k   = codes[$urandom_range(0, 9)];
      rdy = ($urandom_range(0, 99) < 55);
      cyc(r, e, v, x, b, k, rdy);
    end

    // drain and confirm nothing left outstanding
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_outputs();
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
